// File: rtl/membus_pkg.sv
// Shared definitions for the multiplexed memory bus: responder states, bus width, strobe levels.
package membus;

  localparam int BUS_W = 16;

  // Strobes (nME, nOE, nWE) are active-low on the pads.
  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ADDRESSED,
    READ_WAIT,
    READ_DRIVE,
    WRITE_HOLD
  } resp_state_t;

endpackage

// File: rtl/mem_bus_responder_ram.sv
// DEPTH x W word RAM: combinational read, synchronous write with enable; contents are never reset.
module mem_resp_ram #(
  parameter int W     = 16,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          Clock,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [W-1:0]  wdat_i,
  output logic [W-1:0]  rdat_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge Clock) begin
    if (we_i) mem_q[addr_i] <= wdat_i;
  end

  assign rdat_o = mem_q[addr_i];

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder on the multiplexed address/data bus: ALE address latch, range decode,
// read drive with optional wait states, single write per nWE episode. All outputs registered.
module mem_bus_responder #(
  parameter int                 BUS_W       = membus::BUS_W,
  parameter int                 DEPTH       = 1024,
  parameter logic [BUS_W-1:0]   BASE        = '0,
  parameter int                 WAIT_STATES = 0
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic [BUS_W-1:0] AdIn,
  output logic [BUS_W-1:0] AdOut,
  output logic             AdOe,
  input  logic             ALE,
  input  logic             nME,
  input  logic             nOE,
  input  logic             nWE,
  output logic             Ready,
  output logic             Error
);

  import membus::*;

  localparam int AW = $clog2(DEPTH);
  localparam logic [BUS_W:0] BASE_X  = {1'b0, BASE};
  localparam logic [BUS_W:0] LIMIT_X = BASE_X + (BUS_W+1)'(DEPTH);
  localparam logic [3:0]     WS_M1   = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  resp_state_t      state_q, state_d;
  logic [BUS_W-1:0] addr_q, addr_d;
  logic             hit_q, hit_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [BUS_W-1:0] adout_q, adout_d;
  logic             adoe_q, adoe_d;
  logic             ready_q, ready_d;
  logic             error_q, error_d;

  logic             ram_we;
  logic [AW-1:0]    ram_idx;
  logic [BUS_W-1:0] ram_rdat;
  logic             ale_hit;
  logic             sel;
  logic             rd_on, wr_on;

  // Decode is done one bit wider so BASE+DEPTH at the top of the map cannot wrap.
  assign ale_hit = ({1'b0, AdIn} >= BASE_X) && ({1'b0, AdIn} < LIMIT_X);
  assign ram_idx = AW'(addr_q - BASE);
  assign sel     = (nME == STROBE_ON) && hit_q;
  assign rd_on   = (nOE == STROBE_ON);
  assign wr_on   = (nWE == STROBE_ON);

  mem_resp_ram #(
    .W     (BUS_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .Clock  (Clock),
    .we_i   (ram_we),
    .addr_i (ram_idx),
    .wdat_i (AdIn),
    .rdat_o (ram_rdat)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    hit_d   = hit_q;
    cnt_d   = cnt_q;
    adout_d = adout_q;
    adoe_d  = adoe_q;
    ready_d = ready_q;
    error_d = 1'b0;
    ram_we  = 1'b0;

    if (ALE) begin
      // A new address always wins and abandons whatever transfer was in flight.
      addr_d  = AdIn;
      hit_d   = ale_hit;
      state_d = ADDRESSED;
      adoe_d  = 1'b0;
      ready_d = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: ;
        ADDRESSED: begin
          if (sel) begin
            if (rd_on && !wr_on) begin
              if (WAIT_STATES == 0) begin
                adout_d = ram_rdat;
                adoe_d  = 1'b1;
                state_d = READ_DRIVE;
              end else begin
                cnt_d   = WS_M1;
                ready_d = 1'b0;
                state_d = READ_WAIT;
              end
            end else if (wr_on && !rd_on) begin
              ram_we  = 1'b1;
              state_d = WRITE_HOLD;
            end else if (wr_on && rd_on) begin
              error_d = 1'b1;
            end
          end
        end
        READ_WAIT: begin
          if (nOE == STROBE_OFF || nME == STROBE_OFF) begin
            ready_d = 1'b1;
            state_d = ADDRESSED;
          end else if (cnt_q == 4'd0) begin
            adout_d = ram_rdat;
            adoe_d  = 1'b1;
            ready_d = 1'b1;
            state_d = READ_DRIVE;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        READ_DRIVE: begin
          if (nOE == STROBE_OFF || nME == STROBE_OFF) begin
            adoe_d  = 1'b0;
            state_d = ADDRESSED;
          end
        end
        WRITE_HOLD: begin
          // The write already happened on entry; just wait out the strobe.
          if (nWE == STROBE_OFF || nME == STROBE_OFF) state_d = ADDRESSED;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      hit_q   <= 1'b0;
      cnt_q   <= 4'd0;
      adout_q <= '0;
      adoe_q  <= 1'b0;
      ready_q <= 1'b1;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      hit_q   <= hit_d;
      cnt_q   <= cnt_d;
      adout_q <= adout_d;
      adoe_q  <= adoe_d;
      ready_q <= ready_d;
      error_q <= error_d;
    end
  end

  assign AdOut = adout_q;
  assign AdOe  = adoe_q;
  assign Ready = ready_q;
  assign Error = error_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench: three responders share the bus (no wait states, three wait states, BASE=0x0400).
module tb_mem_bus_responder;

  logic        Clock;
  logic        nReset;
  logic [15:0] AdIn;
  logic        ALE, nME, nOE, nWE;

  logic [15:0] out0, out3, outb;
  logic        oe0, oe3, oeb;
  logic        rdy0, rdy3, rdyb;
  logic        err0, err3, errb;

  int errors = 0;
  int checks = 0;

  mem_bus_responder #(.WAIT_STATES(0)) d0 (
    .Clock(Clock), .nReset(nReset), .AdIn(AdIn), .AdOut(out0), .AdOe(oe0),
    .ALE(ALE), .nME(nME), .nOE(nOE), .nWE(nWE), .Ready(rdy0), .Error(err0));

  mem_bus_responder #(.WAIT_STATES(3)) d3 (
    .Clock(Clock), .nReset(nReset), .AdIn(AdIn), .AdOut(out3), .AdOe(oe3),
    .ALE(ALE), .nME(nME), .nOE(nOE), .nWE(nWE), .Ready(rdy3), .Error(err3));

  mem_bus_responder #(.BASE(16'h0400), .DEPTH(1024)) db (
    .Clock(Clock), .nReset(nReset), .AdIn(AdIn), .AdOut(outb), .AdOe(oeb),
    .ALE(ALE), .nME(nME), .nOE(nOE), .nWE(nWE), .Ready(rdyb), .Error(errb));

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic latch(input logic [15:0] a);
    ALE = 1'b1; AdIn = a; tick();
    ALE = 1'b0; AdIn = 16'h0000;
  endtask

  initial begin
    nReset = 1'b0; AdIn = '0; ALE = 1'b0; nME = 1'b1; nOE = 1'b1; nWE = 1'b1;
    tick(); tick();
    chk("rst_adoe",  oe0,  1'b0);
    chk("rst_adout", out0, 16'h0000);
    chk("rst_ready", rdy0, 1'b1);
    chk("rst_error", err0, 1'b0);
    nReset = 1'b1;
    tick();

    // Write BEEF to 0x0010, then fetch it back.
    nME = 1'b0;
    latch(16'h0010);
    nWE = 1'b0; AdIn = 16'hBEEF; tick();
    nWE = 1'b1; AdIn = 16'h0000; tick();
    chk("wr_no_drive", oe0, 1'b0);
    latch(16'h0010);
    nOE = 1'b0; tick();
    chk("rd0_adoe",    oe0,  1'b1);
    chk("rd0_data",    out0, 16'hBEEF);
    chk("ws_rdy_c1",   rdy3, 1'b0);
    chk("ws_oe_c1",    oe3,  1'b0);
    tick();
    chk("rd0_hold",    oe0,  1'b1);
    chk("ws_rdy_c2",   rdy3, 1'b0);
    chk("ws_oe_c2",    oe3,  1'b0);
    tick();
    chk("ws_rdy_c3",   rdy3, 1'b0);
    chk("ws_oe_c3",    oe3,  1'b0);
    tick();
    chk("ws_adoe",     oe3,  1'b1);
    chk("ws_data",     out3, 16'hBEEF);
    chk("ws_rdy_back", rdy3, 1'b1);
    nOE = 1'b1; tick();
    chk("rd0_release", oe0, 1'b0);
    chk("ws_release",  oe3, 1'b0);

    // Asynchronous reset while driving / waiting.
    nOE = 1'b0; tick();
    chk("pre_rst_oe",  oe0,  1'b1);
    chk("pre_rst_rdy", rdy3, 1'b0);
    #1 nReset = 1'b0;
    #1;
    chk("arst_oe",     oe0,  1'b0);
    chk("arst_out",    out0, 16'h0000);
    chk("arst_rdy0",   rdy0, 1'b1);
    chk("arst_rdy3",   rdy3, 1'b1);
    nOE = 1'b1;
    #1 nReset = 1'b1;
    tick();
    nOE = 1'b0; tick();
    chk("post_rst_nohit", oe0, 1'b0);
    nOE = 1'b1; tick();

    // Cancel a wait-state read by releasing nOE early.
    latch(16'h0010);
    nOE = 1'b0; tick();
    chk("cancel_rdy_a", rdy3, 1'b0);
    tick();
    chk("cancel_rdy_b", rdy3, 1'b0);
    nOE = 1'b1; tick();
    chk("cancel_rdy_c", rdy3, 1'b1);
    chk("cancel_oe_a",  oe3,  1'b0);
    tick(); tick(); tick();
    chk("cancel_oe_b",  oe3,  1'b0);

    // Decode with BASE=0x0400: fill first and last words, then probe misses.
    latch(16'h0400);
    nWE = 1'b0; AdIn = 16'hA5A5; tick();
    nWE = 1'b1; tick();
    latch(16'h07FF);
    nWE = 1'b0; AdIn = 16'hCAFE; tick();
    nWE = 1'b1; tick();
    latch(16'h0800);
    nOE = 1'b0; tick();
    chk("miss_hi_oe",  oeb,  1'b0);
    chk("miss_hi_rdy", rdyb, 1'b1);
    nOE = 1'b1; tick();
    nWE = 1'b0; AdIn = 16'h1234; tick();
    nWE = 1'b1; tick();
    chk("miss_wr_err", errb, 1'b0);
    latch(16'h03FF);
    nOE = 1'b0; tick();
    chk("miss_lo_oe", oeb, 1'b0);
    nOE = 1'b1; tick();
    latch(16'h0400);
    nOE = 1'b0; tick();
    chk("base_oe",   oeb,  1'b1);
    chk("base_data", outb, 16'hA5A5);
    nOE = 1'b1; tick();
    latch(16'h07FF);
    nOE = 1'b0; tick();
    chk("top_oe",   oeb,  1'b1);
    chk("top_data", outb, 16'hCAFE);
    nOE = 1'b1; tick();

    // Long write strobe with changing data: only the first value lands.
    latch(16'h0020);
    nWE = 1'b0; AdIn = 16'h1111; tick();
    AdIn = 16'h2222; tick();
    AdIn = 16'h3333; tick();
    AdIn = 16'h4444; tick();
    AdIn = 16'h5555; tick();
    nWE = 1'b1; AdIn = 16'h0000; tick();
    nOE = 1'b0; tick();
    chk("long_wr_data", out0, 16'h1111);
    nOE = 1'b1; tick();

    // Strobe conflict: one-cycle Error, no write, no drive.
    nOE = 1'b0; nWE = 1'b0; AdIn = 16'h9999; tick();
    chk("conflict_err", err0, 1'b1);
    chk("conflict_oe",  oe0,  1'b0);
    nOE = 1'b1; nWE = 1'b1; AdIn = 16'h0000; tick();
    chk("conflict_pulse", err0, 1'b0);
    nOE = 1'b0; tick();
    chk("conflict_nowr", out0, 16'h1111);
    chk("conflict_rd_oe", oe0, 1'b1);

    // ALE during READ_DRIVE aborts the drive and relatches.
    ALE = 1'b1; AdIn = 16'h0010; tick();
    chk("abort_oe", oe0, 1'b0);
    ALE = 1'b0; AdIn = 16'h0000; tick();
    chk("abort_new_oe",   oe0,  1'b1);
    chk("abort_new_data", out0, 16'hBEEF);
    nOE = 1'b1; nME = 1'b1; tick();
    chk("final_release", oe0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
